// File: rtl/vx_mem_perf_monitor.sv
// rtl/vx_mem_perf_monitor.sv - N-channel memory bus performance monitor (reads/writes/rsps/latency/pending)
// Optional peak-pending tracking is enabled by defining PERF_PEAK_TRACK_EN.
module vx_mem_perf_monitor #(
    parameter int NUM_REQS  = 4,
    parameter int CTR_WIDTH = 44,
    parameter int MAX_PEND  = 64,
    parameter int IN_REG    = 1,
    localparam int PEND_W   = $clog2(MAX_PEND + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [NUM_REQS-1:0]  req_valid,
    input  logic [NUM_REQS-1:0]  req_ready,
    input  logic [NUM_REQS-1:0]  req_rw,
    input  logic [NUM_REQS-1:0]  rsp_valid,
    input  logic [NUM_REQS-1:0]  rsp_ready,
    output logic [CTR_WIDTH-1:0] reads,
    output logic [CTR_WIDTH-1:0] writes,
    output logic [CTR_WIDTH-1:0] rsps,
    output logic [CTR_WIDTH-1:0] latency,
    output logic [PEND_W-1:0]    pending,
    output logic [PEND_W-1:0]    peak_pending,
    output logic                 err_underflow,
    output logic                 err_overflow
);

    localparam int CNT_W = $clog2(NUM_REQS + 1);
    localparam int PS_W  = PEND_W + 2;
    localparam int W0    = (CTR_WIDTH > PEND_W) ? CTR_WIDTH : PEND_W;
    localparam int ADD_W = ((W0 > CNT_W) ? W0 : CNT_W) + 1;
    localparam logic [ADD_W-1:0] CTR_MAX = {{(ADD_W-CTR_WIDTH){1'b0}}, {CTR_WIDTH{1'b1}}};

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_REQS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // One extra bit of headroom makes the carry-out the saturation condition.
    function automatic logic [CTR_WIDTH-1:0] sat_add(input logic [CTR_WIDTH-1:0] a,
                                                      input logic [ADD_W-1:0]     b);
        logic [ADD_W-1:0] s;
        s = ADD_W'(a) + b;
        return (s > CTR_MAX) ? {CTR_WIDTH{1'b1}} : s[CTR_WIDTH-1:0];
    endfunction

    logic [NUM_REQS-1:0] rd_fire, wr_fire, rs_fire;
    logic [NUM_REQS-1:0] rd_v, wr_v, rs_v;

    assign rd_fire = req_valid & req_ready & ~req_rw;
    assign wr_fire = req_valid & req_ready & req_rw;
    assign rs_fire = rsp_valid & rsp_ready;

    generate
        if (IN_REG != 0) begin : g_in_reg
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_v <= '0;
                    wr_v <= '0;
                    rs_v <= '0;
                end else begin
                    rd_v <= rd_fire;
                    wr_v <= wr_fire;
                    rs_v <= rs_fire;
                end
            end
        end else begin : g_no_reg
            assign rd_v = rd_fire;
            assign wr_v = wr_fire;
            assign rs_v = rs_fire;
        end
    endgenerate

    logic [CNT_W-1:0]       rd_cnt, wr_cnt, rs_cnt;
    logic signed [PS_W-1:0] pend_sum;
    logic                   pend_under, pend_over;
    logic [PEND_W-1:0]      pend_clamp;

    always_comb begin
        rd_cnt     = popcnt(rd_v);
        wr_cnt     = popcnt(wr_v);
        rs_cnt     = popcnt(rs_v);
        pend_sum   = $signed(PS_W'(pending)) + $signed(PS_W'(rd_cnt)) - $signed(PS_W'(rs_cnt));
        pend_under = pend_sum[PS_W-1];
        pend_over  = !pend_under && (pend_sum > $signed(PS_W'(MAX_PEND)));
        pend_clamp = pend_sum[PEND_W-1:0];
        if (pend_under) begin
            pend_clamp = '0;
        end else if (pend_over) begin
            pend_clamp = PEND_W'(MAX_PEND);
        end
    end

    // pending follows the bus even while counting is disabled or being cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending       <= '0;
            reads         <= '0;
            writes        <= '0;
            rsps          <= '0;
            latency       <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            pending <= pend_clamp;
            if (clear) begin
                reads         <= '0;
                writes        <= '0;
                rsps          <= '0;
                latency       <= '0;
                err_underflow <= 1'b0;
                err_overflow  <= 1'b0;
            end else begin
                err_underflow <= err_underflow | pend_under;
                err_overflow  <= err_overflow | pend_over;
                if (enable) begin
                    reads   <= sat_add(reads,   ADD_W'(rd_cnt));
                    writes  <= sat_add(writes,  ADD_W'(wr_cnt));
                    rsps    <= sat_add(rsps,    ADD_W'(rs_cnt));
                    latency <= sat_add(latency, ADD_W'(pending));
                end
            end
        end
    end

`ifdef PERF_PEAK_TRACK_EN
    logic [PEND_W-1:0] peak_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else if (clear) begin
            peak_q <= '0;
        end else if (pend_clamp > peak_q) begin
            peak_q <= pend_clamp;
        end
    end

    assign peak_pending = peak_q;
`else
    assign peak_pending = '0;
`endif

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// tb/tb_vx_mem_perf_monitor.sv - scoreboard bench for vx_mem_perf_monitor with a behavioural model
module tb_vx_mem_perf_monitor;

    localparam int NUM_REQS  = 4;
    localparam int CTR_WIDTH = 8;
    localparam int MAX_PEND  = 8;
    localparam int IN_REG    = 1;
    localparam int PEND_W    = $clog2(MAX_PEND + 1);
    localparam longint CMAX  = (64'd1 << CTR_WIDTH) - 1;
`ifdef PERF_PEAK_TRACK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 clear = 1'b0;
    logic                 enable = 1'b0;
    logic [NUM_REQS-1:0]  req_valid = '0, req_ready = '0, req_rw = '0;
    logic [NUM_REQS-1:0]  rsp_valid = '0, rsp_ready = '0;
    logic [CTR_WIDTH-1:0] reads, writes, rsps, latency;
    logic [PEND_W-1:0]    pending, peak_pending;
    logic                 err_underflow, err_overflow;

    vx_mem_perf_monitor #(
        .NUM_REQS(NUM_REQS), .CTR_WIDTH(CTR_WIDTH), .MAX_PEND(MAX_PEND), .IN_REG(IN_REG)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .reads(reads), .writes(writes), .rsps(rsps), .latency(latency),
        .pending(pending), .peak_pending(peak_pending),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint reads, writes, rsps, lat, pend, peak;
        bit     uf, of;
    } exp_t;

    exp_t   exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    bit     rst_val = 1'b0;

    // Reference state: counters as integers, bus events delayed by one cycle when IN_REG=1.
    longint m_reads = 0, m_writes = 0, m_rsps = 0, m_lat = 0, m_pend = 0, m_peak = 0;
    bit     m_uf = 0, m_of = 0;
    int     p_rd = 0, p_wr = 0, p_rs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic step(input logic [3:0] rv, input logic [3:0] rr, input logic [3:0] rw,
                        input logic [3:0] sv, input logic [3:0] sr, input bit en, input bit clr);
        int     rd, wr, rs, ad, aw, as;
        longint np;
        exp_t   e;
        @(negedge clk);
        reset = rst_val;
        req_valid = rv; req_ready = rr; req_rw = rw;
        rsp_valid = sv; rsp_ready = sr;
        enable = en; clear = clr;
        rd = $countones(rv & rr & ~rw);
        wr = $countones(rv & rr & rw);
        rs = $countones(sv & sr);
        if (IN_REG != 0) begin
            ad = p_rd; aw = p_wr; as = p_rs;
        end else begin
            ad = rd; aw = wr; as = rs;
        end
        if (!reset) begin
            m_reads = 0; m_writes = 0; m_rsps = 0; m_lat = 0; m_pend = 0; m_peak = 0;
            m_uf = 0; m_of = 0; p_rd = 0; p_wr = 0; p_rs = 0;
        end else begin
            np = m_pend + ad - as;
            if (np < 0) begin
                m_uf = 1; np = 0;
            end else if (np > MAX_PEND) begin
                m_of = 1; np = MAX_PEND;
            end
            if (clr) begin
                m_reads = 0; m_writes = 0; m_rsps = 0; m_lat = 0; m_peak = 0;
                m_uf = 0; m_of = 0;
            end else begin
                if (en) begin
                    m_reads  = sat(m_reads + ad);
                    m_writes = sat(m_writes + aw);
                    m_rsps   = sat(m_rsps + as);
                    m_lat    = sat(m_lat + m_pend);
                end
                if (PEAK_EN && np > m_peak) m_peak = np;
            end
            m_pend = np;
            p_rd = rd; p_wr = wr; p_rs = rs;
        end
        e.reads = m_reads; e.writes = m_writes; e.rsps = m_rsps; e.lat = m_lat;
        e.pend = m_pend; e.peak = m_peak; e.uf = m_uf; e.of = m_of;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, en, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rst_val = 1'b0;
        #1;
        chk("async_rst_reads", reads, 0);
        chk("async_rst_writes", writes, 0);
        chk("async_rst_latency", latency, 0);
        chk("async_rst_pending", pending, 0);
        chk("async_rst_err", {err_underflow, err_overflow}, 0);
        idle(2, 1'b1);
        rst_val = 1'b1;
    endtask

    // Monitor: outputs settle after each posedge, one expected snapshot per stimulus cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("reads", reads, e.reads);
                chk("writes", writes, e.writes);
                chk("rsps", rsps, e.rsps);
                chk("latency", latency, e.lat);
                chk("pending", pending, e.pend);
                chk("peak_pending", peak_pending, e.peak);
                chk("err_underflow", err_underflow, e.uf);
                chk("err_overflow", err_overflow, e.of);
            end
        end
    end

    initial begin
        #1;
        chk("reset_pending", pending, 0);
        chk("reset_reads", reads, 0);
        idle(2, 1'b1);
        rst_val = 1'b1;

        step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        step(4'b0111, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t1_reads", reads, 3);
        chk("t1_pending", pending, 3);
        chk("t1_writes", writes, 0);

        step(4'h0, 4'h0, 4'h0, 4'b0111, 4'hF, 1'b0, 1'b0);
        idle(2, 1'b1);
        step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        step(4'b0001, 4'b0001, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(4'h0, 4'h0, 4'h0, 4'b0001, 4'b0001, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t2_latency", latency, 5);
        chk("t2_reads", reads, 1);
        chk("t2_rsps", rsps, 1);
        chk("t2_pending", pending, 0);

        step(4'h0, 4'h0, 4'h0, 4'b0010, 4'b0010, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t3_underflow", err_underflow, 1);
        chk("t3_pending", pending, 0);
        idle(3, 1'b1);
        chk("t3_sticky", err_underflow, 1);
        step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("t3_cleared", err_underflow, 0);

        for (int i = 0; i < 3; i++) step(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t4_pending", pending, MAX_PEND);
        chk("t4_overflow", err_overflow, 1);
        chk("t4_peak", peak_pending, PEAK_EN ? MAX_PEND : 0);
        for (int i = 0; i < 2; i++) step(4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0);
        idle(2, 1'b1);

        step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        step(4'b0001, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(2, 1'b1);
        step(4'b0011, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        idle(1, 1'b0);
        chk("t5_reads", reads, 0);
        chk("t5_pending", pending, 3);
        for (int i = 0; i < 2; i++) step(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("t5_hold_writes", writes, 0);
        chk("t5_hold_pending", pending, 3);
        step(4'h0, 4'h0, 4'h0, 4'b0111, 4'hF, 1'b0, 1'b0);

        step(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 70; i++) step(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t6_writes_sat", writes, CMAX);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom & $urandom), 4'($urandom),
                 ($urandom % 8) != 0, ($urandom % 64) == 0);
        end
        idle(2, 1'b1);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
